// File: rtl/rf_controller.sv
// rf_controller: five-state micro-sequencer that drives the Acc/B..G register file (optional flags under RF_CTRL_FLAGS_EN)
module rf_controller #(
  parameter int DATA_W   = 8,
  parameter int SEL_W    = 3,
  parameter int NUM_REGS = 7
) (
  input  logic              Ctl_clk,
  input  logic              Ctl_rst_n,
  input  logic [15:0]       Instr_in,
  input  logic              Instr_valid,
  output logic              Instr_ready,
  output logic [SEL_W-1:0]  Select,
  output logic [DATA_W-1:0] Data_in,
  output logic              RF_we,
  output logic [DATA_W-1:0] Acc_in,
  output logic              Acc_we,
  input  logic [DATA_W-1:0] Data_out,
  input  logic [DATA_W-1:0] Acc_out,
  output logic              Done,
  output logic              Err,
  output logic              Flag_c,
  output logic              Flag_z
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE} state_t;
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_MOVA = 4'd2;
  localparam logic [3:0] OP_MOVR = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_REGS - 1);

  state_t            st, nxt;
  logic [3:0]        opc_q;
  logic [SEL_W-1:0]  rsel_q, sel_q;
  logic [DATA_W-1:0] imm_q, a_q, r_q, res_q;
  logic              err_q;
  logic [DATA_W:0]   alu;
  logic              bad, to_acc, rf_path, acc_path;

  // Operand range checks only apply to opcodes that name a register.
  assign bad      = opc_q > OP_ADDI || (opc_q != OP_NOP && opc_q != OP_ADDI && rsel_q > MAX_SEL);
  assign to_acc   = opc_q >= OP_MOVR && opc_q <= OP_XOR;
  // An accumulator result with rsel==0 (and ADDI) must go through the RF port, since the RF drops Acc_we at select 0.
  assign rf_path  = opc_q == OP_LDI || opc_q == OP_MOVA || opc_q == OP_ADDI || (to_acc && rsel_q == '0);
  assign acc_path = to_acc && rsel_q != '0;

  // State register
  always_ff @(posedge Ctl_clk)
    if (!Ctl_rst_n) st <= S_IDLE;
    else st <= nxt;

  // Next-state logic
  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:  nxt = Instr_valid ? S_READ : S_IDLE;
      S_READ:  nxt = bad ? S_DONE : S_EXEC;
      S_EXEC:  nxt = S_WRITE;
      S_WRITE: nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  // Instruction latch, operand capture, result and select registers
  always_ff @(posedge Ctl_clk)
    if (!Ctl_rst_n) begin
      opc_q  <= '0;
      rsel_q <= '0;
      imm_q  <= '0;
      sel_q  <= '0;
      a_q    <= '0;
      r_q    <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (st == S_IDLE && Instr_valid) begin
        opc_q  <= Instr_in[15:12];
        rsel_q <= Instr_in[8 +: SEL_W];
        imm_q  <= Instr_in[0 +: DATA_W];
        sel_q  <= Instr_in[8 +: SEL_W];
      end
      if (st == S_READ) begin
        a_q   <= Acc_out;
        r_q   <= Data_out;
        err_q <= bad;
      end
      if (st == S_EXEC) begin
        res_q <= alu[DATA_W-1:0];
        sel_q <= opc_q == OP_ADDI ? '0 : rsel_q;
      end
    end

  // Single-operand ALU; bit DATA_W is carry (ADD/ADDI) or borrow (SUB)
  always_comb begin
    alu = '0;
    case (opc_q)
      OP_LDI:  alu = {1'b0, imm_q};
      OP_MOVA: alu = {1'b0, a_q};
      OP_MOVR: alu = {1'b0, r_q};
      OP_ADD:  alu = {1'b0, a_q} + {1'b0, r_q};
      OP_SUB:  alu = {1'b0, a_q} - {1'b0, r_q};
      OP_AND:  alu = {1'b0, a_q & r_q};
      OP_OR:   alu = {1'b0, a_q | r_q};
      OP_XOR:  alu = {1'b0, a_q ^ r_q};
      OP_ADDI: alu = {1'b0, a_q} + {1'b0, imm_q};
      default: alu = '0;
    endcase
  end

`ifdef RF_CTRL_FLAGS_EN
  // Flags follow ALU opcodes only, updated as the result is registered
  always_ff @(posedge Ctl_clk)
    if (!Ctl_rst_n) begin
      Flag_c <= 1'b0;
      Flag_z <= 1'b0;
    end else if (st == S_EXEC && opc_q >= OP_ADD && opc_q <= OP_ADDI) begin
      Flag_c <= alu[DATA_W];
      Flag_z <= alu[DATA_W-1:0] == '0;
    end
`else
  logic unused_carry;
  assign unused_carry = alu[DATA_W];
  assign Flag_c = 1'b0;
  assign Flag_z = 1'b0;
`endif

  // Output decode: strobes and data only in their own cycle, select held
  always_comb begin
    Instr_ready = st == S_IDLE;
    Select      = sel_q;
    RF_we       = st == S_WRITE && rf_path;
    Acc_we      = st == S_WRITE && acc_path;
    Data_in     = RF_we ? res_q : '0;
    Acc_in      = Acc_we ? res_q : '0;
    Done        = st == S_DONE;
    Err         = st == S_DONE && err_q;
  end
endmodule

// File: tb/tb_rf_controller.sv
// tb_rf_controller: directed test of rf_controller against a behavioural register file
module tb_rf_controller;
`ifdef RF_CTRL_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif
  logic        Ctl_clk = 1'b0;
  logic        Ctl_rst_n;
  logic [15:0] Instr_in;
  logic        Instr_valid;
  logic        Instr_ready;
  logic [2:0]  Select;
  logic [7:0]  Data_in, Acc_in, Data_out, Acc_out;
  logic        RF_we, Acc_we, Done, Err, Flag_c, Flag_z;
  logic [7:0]  regs [0:7] = '{default: 8'h00};
  int          pass_cnt = 0, total_cnt = 0;
  int          rf_cnt, acc_cnt, done_cyc;
  logic [2:0]  rf_sel, acc_sel;
  logic [7:0]  rf_data, acc_data;
  logic        err_seen;

  rf_controller dut (
    .Ctl_clk(Ctl_clk), .Ctl_rst_n(Ctl_rst_n), .Instr_in(Instr_in), .Instr_valid(Instr_valid),
    .Instr_ready(Instr_ready), .Select(Select), .Data_in(Data_in), .RF_we(RF_we),
    .Acc_in(Acc_in), .Acc_we(Acc_we), .Data_out(Data_out), .Acc_out(Acc_out),
    .Done(Done), .Err(Err), .Flag_c(Flag_c), .Flag_z(Flag_z)
  );

  always #5 Ctl_clk = ~Ctl_clk;

  assign Data_out = regs[Select];
  assign Acc_out  = regs[0];
  always @(posedge Ctl_clk) begin
    if (RF_we) regs[Select] <= Data_in;
    if (Acc_we && Select != 3'd0) regs[0] <= Acc_in;
  end

  task automatic send(input logic [15:0] ins);
    int k;
    rf_cnt = 0; acc_cnt = 0; done_cyc = 0; err_seen = 1'b0;
    rf_sel = 0; rf_data = 0; acc_sel = 0; acc_data = 0;
    @(negedge Ctl_clk);
    Instr_in = ins;
    Instr_valid = 1'b1;
    k = 0;
    while (!Instr_ready && k < 20) begin
      @(negedge Ctl_clk);
      k++;
    end
    if (!Instr_ready) begin
      total_cnt++;
      $display("FAIL send_timeout %h: Instr_ready=%b want 1", ins, Instr_ready);
      Instr_valid = 1'b0;
      return;
    end
    @(posedge Ctl_clk);
    #1 Instr_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Ctl_clk);
      if (RF_we) begin rf_cnt++; rf_sel = Select; rf_data = Data_in; end
      if (Acc_we) begin acc_cnt++; acc_sel = Select; acc_data = Acc_in; end
      if (Done && done_cyc == 0) begin done_cyc = c; err_seen = Err; end
    end
  endtask

  task automatic test_reset;
    total_cnt++;
    if ({Instr_ready, Select, Data_in, Acc_in, RF_we, Acc_we, Done, Err, Flag_c, Flag_z} !== {1'b1, 25'd0})
      $display("FAIL reset_state: got %b want %b",
               {Instr_ready, Select, Data_in, Acc_in, RF_we, Acc_we, Done, Err, Flag_c, Flag_z}, {1'b1, 25'd0});
    else pass_cnt++;
  endtask

  task automatic test_ldi_setup;
    send(16'h1049);
    total_cnt++;
    if ({rf_cnt, acc_cnt, rf_sel, rf_data} !== {32'd1, 32'd0, 3'd0, 8'h49})
      $display("FAIL ldi_acc: rf_cnt=%0d acc_cnt=%0d sel=%0d data=%h want 1 0 0 49", rf_cnt, acc_cnt, rf_sel, rf_data);
    else pass_cnt++;
    send(16'h1106);
  endtask

  task automatic test_add;
    send(16'h4100);
    total_cnt++;
    if ({acc_cnt, rf_cnt, acc_sel, acc_data} !== {32'd1, 32'd0, 3'd1, 8'h4F})
      $display("FAIL add_write: acc_cnt=%0d rf_cnt=%0d sel=%0d acc_in=%h want 1 0 1 4f", acc_cnt, rf_cnt, acc_sel, acc_data);
    else pass_cnt++;
    total_cnt++;
    if ({done_cyc, err_seen} !== {32'd4, 1'b0})
      $display("FAIL add_done: done_cyc=%0d err=%b want 4 0", done_cyc, err_seen);
    else pass_cnt++;
    total_cnt++;
    if ({Flag_c, Flag_z} !== 2'b00) $display("FAIL add_flags: got %b want 00", {Flag_c, Flag_z});
    else pass_cnt++;
  endtask

  task automatic test_ldi_sub;
    send(16'h1250);
    total_cnt++;
    if ({rf_cnt, acc_cnt, rf_sel, rf_data} !== {32'd1, 32'd0, 3'd2, 8'h50})
      $display("FAIL ldi_c: rf_cnt=%0d acc_cnt=%0d sel=%0d data=%h want 1 0 2 50", rf_cnt, acc_cnt, rf_sel, rf_data);
    else pass_cnt++;
    send(16'h5200);
    total_cnt++;
    if ({acc_cnt, acc_sel, acc_data} !== {32'd1, 3'd2, 8'hFF})
      $display("FAIL sub_write: acc_cnt=%0d sel=%0d acc_in=%h want 1 2 ff", acc_cnt, acc_sel, acc_data);
    else pass_cnt++;
    total_cnt++;
    if ({Flag_c, Flag_z} !== {FL, 1'b0}) $display("FAIL sub_flags: got %b want %b", {Flag_c, Flag_z}, {FL, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_add_r0;
    send(16'h1049);
    send(16'h4000);
    total_cnt++;
    if ({rf_cnt, acc_cnt, rf_sel, rf_data} !== {32'd1, 32'd0, 3'd0, 8'h92})
      $display("FAIL add_r0: rf_cnt=%0d acc_cnt=%0d sel=%0d data=%h want 1 0 0 92", rf_cnt, acc_cnt, rf_sel, rf_data);
    else pass_cnt++;
    total_cnt++;
    if ({Flag_c, Flag_z} !== 2'b00) $display("FAIL add_r0_flags: got %b want 00", {Flag_c, Flag_z});
    else pass_cnt++;
  endtask

  task automatic test_xor;
    send(16'h1006);
    send(16'h8100);
    total_cnt++;
    if ({acc_cnt, acc_sel, acc_data} !== {32'd1, 3'd1, 8'h00})
      $display("FAIL xor_write: acc_cnt=%0d sel=%0d acc_in=%h want 1 1 00", acc_cnt, acc_sel, acc_data);
    else pass_cnt++;
    total_cnt++;
    if ({Flag_c, Flag_z} !== {1'b0, FL}) $display("FAIL xor_flags: got %b want %b", {Flag_c, Flag_z}, {1'b0, FL});
    else pass_cnt++;
  endtask

  task automatic test_illegal;
    logic [15:0] vec [2] = '{16'hF100, 16'h1755};
    for (int i = 0; i < 2; i++) begin
      send(vec[i]);
      total_cnt++;
      if ({rf_cnt, acc_cnt, done_cyc, err_seen} !== {32'd0, 32'd0, 32'd2, 1'b1})
        $display("FAIL illegal_%h: rf_cnt=%0d acc_cnt=%0d done_cyc=%0d err=%b want 0 0 2 1",
                 vec[i], rf_cnt, acc_cnt, done_cyc, err_seen);
      else pass_cnt++;
      total_cnt++;
      if ({Flag_c, Flag_z} !== {1'b0, FL}) $display("FAIL illegal_flags_%h: got %b want %b", vec[i], {Flag_c, Flag_z}, {1'b0, FL});
      else pass_cnt++;
    end
  endtask

  task automatic test_addi_mov;
    send(16'h9080);
    total_cnt++;
    if ({rf_cnt, acc_cnt, rf_sel, rf_data} !== {32'd1, 32'd0, 3'd0, 8'h80})
      $display("FAIL addi: rf_cnt=%0d acc_cnt=%0d sel=%0d data=%h want 1 0 0 80", rf_cnt, acc_cnt, rf_sel, rf_data);
    else pass_cnt++;
    send(16'h2380);
    total_cnt++;
    if ({rf_cnt, rf_sel, rf_data} !== {32'd1, 3'd3, 8'h80})
      $display("FAIL mova: rf_cnt=%0d sel=%0d data=%h want 1 3 80", rf_cnt, rf_sel, rf_data);
    else pass_cnt++;
    send(16'h3200);
    total_cnt++;
    if ({acc_cnt, acc_sel, acc_data} !== {32'd1, 3'd2, 8'h50})
      $display("FAIL movr: acc_cnt=%0d sel=%0d acc_in=%h want 1 2 50", acc_cnt, acc_sel, acc_data);
    else pass_cnt++;
    send(16'h90B0);
    total_cnt++;
    if ({rf_cnt, rf_sel, rf_data} !== {32'd1, 3'd0, 8'h00})
      $display("FAIL addi_wrap: rf_cnt=%0d sel=%0d data=%h want 1 0 00", rf_cnt, rf_sel, rf_data);
    else pass_cnt++;
    total_cnt++;
    if ({Flag_c, Flag_z} !== {FL, FL}) $display("FAIL addi_flags: got %b want %b", {Flag_c, Flag_z}, {FL, FL});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int acc_n, first, last, we_n;
    acc_n = 0; first = -1; last = -1; we_n = 0;
    @(negedge Ctl_clk);
    Instr_in = 16'h1511;
    Instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (Instr_ready) begin
        acc_n++;
        if (first < 0) first = i;
        last = i;
      end
      if (RF_we) we_n++;
      @(negedge Ctl_clk);
    end
    Instr_valid = 1'b0;
    total_cnt++;
    if ({acc_n, first, last} !== {32'd4, 32'd0, 32'd15})
      $display("FAIL b2b_accepts: n=%0d first=%0d last=%0d want 4 0 15", acc_n, first, last);
    else pass_cnt++;
    total_cnt++;
    if (we_n !== 4) $display("FAIL b2b_writes: got %0d want 4", we_n);
    else pass_cnt++;
    repeat (6) @(negedge Ctl_clk);
  endtask

  task automatic test_reset_mid;
    int we_n;
    send(16'h1049);
    @(negedge Ctl_clk);
    Instr_in = 16'h4100;
    Instr_valid = 1'b1;
    @(posedge Ctl_clk);
    #1 Instr_valid = 1'b0;
    @(negedge Ctl_clk);
    @(negedge Ctl_clk);
    Ctl_rst_n = 1'b0;
    @(negedge Ctl_clk);
    Ctl_rst_n = 1'b1;
    total_cnt++;
    if ({Instr_ready, Select, Data_in, Acc_in, RF_we, Acc_we, Done, Err, Flag_c, Flag_z} !== {1'b1, 25'd0})
      $display("FAIL reset_mid_state: got %b want %b",
               {Instr_ready, Select, Data_in, Acc_in, RF_we, Acc_we, Done, Err, Flag_c, Flag_z}, {1'b1, 25'd0});
    else pass_cnt++;
    we_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (RF_we || Acc_we || Done) we_n++;
      @(negedge Ctl_clk);
    end
    total_cnt++;
    if ({we_n, regs[0]} !== {32'd0, 8'h49})
      $display("FAIL reset_mid_abort: strobes=%0d acc=%h want 0 49", we_n, regs[0]);
    else pass_cnt++;
  endtask

  initial begin
    Ctl_rst_n = 1'b0;
    Instr_in = 16'h0000;
    Instr_valid = 1'b0;
    repeat (2) @(posedge Ctl_clk);
    @(negedge Ctl_clk);
    Ctl_rst_n = 1'b1;
    test_reset;
    test_ldi_setup;
    test_add;
    test_ldi_sub;
    test_add_r0;
    test_xor;
    test_illegal;
    test_addi_mov;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
